// File: rtl/uart_tx.sv
// Serial transmitter: takes a parallel word on a valid/ready handshake and sends it
// as a start bit, DATA_BITS data bits (LSB first) and one stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_VALID,
  output logic                 TX_READY,
  output logic                 TX,
  output logic                 BUSY
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 baud_tc;

  assign baud_tc = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (ready_q && TX_VALID) begin
          shift_d = TX_DATA;
          state_d = START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
        end
      end

      START: begin
        if (baud_tc) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          bit_d   = '0;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q < BIT_LAST) begin
            // shift_q[1] becomes the new LSB, so it is the next bit on the line
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + BIT_W'(1);
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (baud_tc) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign TX       = tx_q;
  assign TX_READY = ready_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frame tables, corner sequences and random traffic
// checked every cycle against a frame-timing reference model.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int FRAME = (DB + 2) * CPB;

  logic       CLK;
  logic       RST;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic       TX;
  logic       BUSY;

  logic [4:0] d1;
  logic       v1;
  logic       rdy1;
  logic       tx1;
  logic       busy1;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) u0 (
    .CLK(CLK), .RST(RST), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY), .TX(TX), .BUSY(BUSY)
  );

  uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5)) u1 (
    .CLK(CLK), .RST(RST), .TX_DATA(d1), .TX_VALID(v1),
    .TX_READY(rdy1), .TX(tx1), .BUSY(busy1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: a frame is FRAME cycles long counted from the accepting edge;
  // cycle k carries line bit k/CPB of {stop, data, start}.
  bit         m_active = 1'b0;
  int         m_k = 0;
  logic [7:0] m_word = '0;

  function automatic logic line_bit(input int k, input logic [7:0] w);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= DB) return w[b-1];
    return 1'b1;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_k++;
      if (m_k == FRAME) m_active = 1'b0;
    end else if (TX_VALID) begin
      m_active = 1'b1;
      m_k      = 0;
      m_word   = TX_DATA;
    end
  end

  always @(negedge CLK) begin
    check("model_tx", TX, m_active ? line_bit(m_k, m_word) : 1'b1);
    check("model_ready", TX_READY, !m_active);
    check("model_busy", BUSY, m_active);
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit 0 is the first bit on the line
  } vec_t;

  vec_t vecs[3];

  task automatic wait_ready();
    int n = 0;
    while (TX_READY !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("wait_ready", TX_READY, 1'b1);
  endtask

  task automatic start_frame(input logic [7:0] d);
    wait_ready();
    TX_DATA  = d;
    TX_VALID = 1'b1;
    @(negedge CLK);
    check("accept_ready", TX_READY, 1'b0);
  endtask

  // Entered at the negedge right after the accepting edge; leaves FRAME cycles later.
  task automatic run_frame(input logic [9:0] exp, input bit toggle);
    for (int k = 0; k < FRAME; k++) begin
      check("frame_tx", TX, exp[k / CPB]);
      check("frame_ready", TX_READY, 1'b0);
      check("frame_busy", BUSY, 1'b1);
      if (toggle && k < FRAME - 2) begin
        TX_DATA  = 8'h3C;
        TX_VALID = k[0];
      end else if (toggle) begin
        TX_VALID = 1'b0;
      end
      @(negedge CLK);
    end
    check("latency_ready", TX_READY, 1'b1);
    check("latency_busy", BUSY, 1'b0);
  endtask

  initial begin
    logic [6:0] exp7;

    vecs[0] = '{data: 8'hA5, frame: 10'b1_10100101_0};
    vecs[1] = '{data: 8'h3C, frame: 10'b1_00111100_0};
    vecs[2] = '{data: 8'h81, frame: 10'b1_10000001_0};

    RST = 1'b1; TX_VALID = 1'b1; TX_DATA = 8'hA5;
    d1 = '0; v1 = 1'b0;

    // reset held with VALID asserted
    repeat (3) begin
      @(negedge CLK);
      check("rst_tx", TX, 1'b1);
      check("rst_ready", TX_READY, 1'b1);
      check("rst_busy", BUSY, 1'b0);
    end
    RST = 1'b0; TX_VALID = 1'b0;
    @(negedge CLK);
    check("post_rst_idle", TX_READY, 1'b1);

    // table of single frames
    for (int i = 0; i < 3; i++) begin
      start_frame(vecs[i].data);
      TX_VALID = 1'b0;
      run_frame(vecs[i].frame, 1'b0);
    end

    // back-to-back with VALID held: second accept on the first ready edge
    start_frame(8'h00);
    TX_DATA = 8'hFF;
    run_frame(10'b1_00000000_0, 1'b0);
    @(negedge CLK);
    check("b2b_accept", TX_READY, 1'b0);
    check("b2b_start", TX, 1'b0);
    TX_VALID = 1'b0;
    run_frame(10'b1_11111111_0, 1'b0);

    // input changes during a frame are ignored
    start_frame(8'hA5);
    TX_VALID = 1'b0;
    run_frame(10'b1_10100101_0, 1'b1);
    repeat (3) begin
      @(negedge CLK);
      check("no_extra_frame", TX_READY, 1'b1);
      check("no_extra_tx", TX, 1'b1);
    end

    // reset during the third data bit of 8'h55
    start_frame(8'h55);
    TX_VALID = 1'b0;
    repeat (13) @(negedge CLK);
    check("pre_rst_busy", BUSY, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("midrst_tx", TX, 1'b1);
    check("midrst_ready", TX_READY, 1'b1);
    check("midrst_busy", BUSY, 1'b0);
    repeat (4) begin
      @(negedge CLK);
      check("midrst_quiet", TX, 1'b1);
    end
    start_frame(8'h81);
    TX_VALID = 1'b0;
    run_frame(10'b1_10000001_0, 1'b0);

    // CLKS_PER_BIT=2, DATA_BITS=5 instance
    exp7 = 7'b1_10011_0;
    check("u1_idle", rdy1, 1'b1);
    d1 = 5'h13; v1 = 1'b1;
    @(negedge CLK);
    v1 = 1'b0;
    for (int k = 0; k < 14; k++) begin
      check("u1_tx", tx1, exp7[k / 2]);
      check("u1_ready", rdy1, 1'b0);
      @(negedge CLK);
    end
    check("u1_latency", rdy1, 1'b1);
    check("u1_busy", busy1, 1'b0);

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      TX_VALID = ($urandom_range(0, 3) != 0);
      TX_DATA  = 8'($urandom);
      RST      = ($urandom_range(0, 199) == 0);
      @(negedge CLK);
    end
    RST = 1'b0; TX_VALID = 1'b0;
    repeat (FRAME + 2) @(negedge CLK);
    check("final_idle", TX_READY, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
